btb_wr_ctrl: RTL
================

Name: btb_wr_ctrl

Overview:
- Write-port controller for the branch target buffer (1024 x 34-bit dual-port RAM; data word is {counter[1:0], target[31:0]}).
- Zero-initialises the RAM after reset and on flush. Commits each EX-stage branch update exactly once, regardless of pipeline stalls.
- Defers writes that collide with the same-cycle read address. Forwards pending (not yet written) entries to the predictor read path.

Parameters:
- IDX_W, 10, BTB index width; index = pc[IDX_W+1:2].
- DATA_W, 34, BTB entry width.
- FIFO_DEPTH, 4, pending-update queue depth (power of 2, >=2).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- stall  in  6  pipeline stall vector; stall[3]=1 holds EX.
- ex_upd_valid_i  in  1  EX holds a resolved branch.
- ex_upd_pc_i  in  32  PC of that branch.
- ex_upd_data_i  in  DATA_W  new {counter,target} word.
- flush_req_i  in  1  request full BTB clear (single-cycle pulse).
- rd_pc_i  in  32  predictor read PC, same cycle as the RAM read address.
- btb_we_o  out  1  RAM write enable.
- btb_waddr_o  out  IDX_W  RAM write index.
- btb_wdata_o  out  DATA_W  RAM write data.
- rd_fwd_hit_o  out  1  pending entry matches the previous cycle's rd index.
- rd_fwd_data_o  out  DATA_W  forwarded word, valid when hit.
- init_busy_o  out  1  sweep in progress; predictions must be ignored.
- upd_drop_o  out  1  one-cycle pulse: an update was discarded.

Behaviour:
- All outputs registered. On rst: state INIT, sweep pointer 0, FIFO empty; btb_we_o=0, btb_waddr_o=0, btb_wdata_o=0, rd_fwd_hit_o=0, rd_fwd_data_o=0, init_busy_o=1, upd_drop_o=0.
- FSM states INIT, RUN, FLUSH:
  - INIT and FLUSH write zero to index ptr each cycle (btb_we_o=1), ptr++.
  - After index 2^IDX_W-1 is written, go to RUN. A sweep takes exactly 1024 cycles with btb_we_o high.
  - In RUN, flush_req_i=1 goes to FLUSH next cycle and clears the FIFO. flush_req_i during INIT or FLUSH is ignored; the sweep is not restarted.
  - rst mid-sweep restarts INIT from index 0.
- Update accept: only in RUN, on a cycle with ex_upd_valid_i=1 and stall[3]=0. Stalled EX cycles never enqueue, so each branch is taken once.
  - Updates arriving in INIT or FLUSH are discarded and pulse upd_drop_o.
- Enqueue and coalescing:
  - If the accepted index equals the index of any FIFO entry, that entry's data is overwritten in place (no push).
  - Otherwise push. If the FIFO is full and nothing coalesces, drop the update and pulse upd_drop_o.
- Issue (RUN): the head entry is written next cycle unless head index == rd_pc_i[IDX_W+1:2] in the current cycle. In that case hold it (collision defer), btb_we_o=0.
  - One pop max per cycle.
  - Push and pop in the same cycle are allowed, including when full.
  - Coalescing into the head entry while it is being popped writes the new data: the newer value wins.
- Write latency: an update accepted into an empty FIFO with no collision appears on btb_we_o in cycle N+2. N+1 is enqueue, N+2 is issue register.
- Forwarding: rd_fwd_hit_o/rd_fwd_data_o are registered one cycle after rd_pc_i, aligned with RAM doutb.
  - Hit if any valid FIFO entry, or the write being issued that cycle, matches the rd index.
  - FIFO data has priority over the issuing write.
  - During INIT/FLUSH: hit=1, data=0.

Optional Feature:
- Macro BTB_WR_STATS_EN.
- Defined: adds outputs stat_upd_o[31:0] (accepted updates), stat_drop_o[31:0] (drops), stat_defer_o[31:0] (collision-deferred cycles). Counters are saturating, reset to 0, and not cleared by flush.
- Undefined: these ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Package btb_pkg: IDX_W, DATA_W, FSM state enum (INIT/RUN/FLUSH), pending-entry typedef {valid, idx, data}.
- One sub-module, btb_upd_fifo: coalescing CAM-style FIFO with lookup port. The FSM, issue register and forwarding mux stay at top level.

Test Plan:
- Reset, run 1024 cycles -> btb_we_o=1 with waddr 0..1023 and wdata=0. Cycle 1025: init_busy_o=0, state RUN.
- RUN, valid update pc=0x0000_0104, data=0x3_8000_0040, stall=0 at cycle N -> cycle N+2: we=1, waddr=0x041, wdata=0x3_8000_0040.
- Same update held 5 cycles with stall[3]=1 then 1 cycle stall[3]=0 -> exactly one RAM write.
- rd_pc_i=0x104 held constant while updates to 0x104 and 0x204 arrive -> 0x104 write deferred; rd_fwd_hit_o=1 with the new data; 0x204 stays queued behind it. Releasing rd_pc_i -> both written in order.
- Five distinct-index updates on back-to-back cycles during a persistent collision on the head -> four queued, fifth pulses upd_drop_o. A sixth update to a queued index coalesces with no drop.
- flush_req_i in RUN with 3 pending entries -> FIFO emptied, 1024-cycle zero sweep, an update arriving mid-sweep pulses upd_drop_o; rst asserted at sweep index 500 -> INIT restarts at index 0.

Source files
------------

// File: rtl/btb_pkg.sv
// btb_pkg: shared widths, FSM state encoding, pending-entry type and a small
// saturating-increment helper for the BTB write-port controller.
package btb_pkg;

    localparam int IDX_W  = 10;
    localparam int DATA_W = 34;

    // Controller mode: zero sweep after reset, normal update traffic, zero sweep after flush.
    typedef enum logic [1:0] {
        INIT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } btb_state_e;

    // One queued BTB update that has not yet been written to the RAM.
    typedef struct packed {
        logic              valid;
        logic [IDX_W-1:0]  idx;
        logic [DATA_W-1:0] data;
    } pend_entry_t;

    // Event counter step that sticks at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/btb_upd_fifo.sv
// btb_upd_fifo: in-order queue of pending BTB updates. An update whose index is
// already queued overwrites that entry's data in place instead of pushing, so
// every queued index is unique and the lookup port returns at most one match.
module btb_upd_fifo #(
    parameter int IDX_W  = btb_pkg::IDX_W,
    parameter int DATA_W = btb_pkg::DATA_W,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_i,
    input  logic              push_i,
    input  logic [IDX_W-1:0]  push_idx_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              pop_i,
    input  logic [IDX_W-1:0]  lk_idx_i,
    output logic              empty_o,
    output logic [IDX_W-1:0]  head_idx_o,
    output logic [DATA_W-1:0] head_data_o,
    output logic              drop_o,
    output logic              lk_hit_o,
    output logic [DATA_W-1:0] lk_data_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DEPTH-1:0]  valid_q;
    logic [IDX_W-1:0]  idx_q  [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [PTR_W-1:0]  head_q;
    logic [PTR_W-1:0]  tail_q;

    logic [DEPTH-1:0]  co_match;
    logic              co_hit;
    logic              full;
    logic              do_push;

    // CAM compare of the incoming update and of the read index against every live entry.
    always_comb begin
        co_match  = '0;
        lk_hit_o  = 1'b0;
        lk_data_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            co_match[i] = valid_q[i] && (idx_q[i] == push_idx_i);
            if (valid_q[i] && (idx_q[i] == lk_idx_i)) begin
                lk_hit_o  = 1'b1;
                lk_data_o = data_q[i];
            end
        end
    end

    assign co_hit     = |co_match;
    // Occupancy is contiguous from head, so a live tail slot means every slot is live.
    assign full       = valid_q[tail_q];
    assign empty_o    = ~valid_q[head_q];
    assign head_idx_o = idx_q[head_q];
    // A same-cycle coalesce into the head must reach the RAM, not the stale value.
    assign head_data_o = (push_i && co_match[head_q]) ? push_data_i : data_q[head_q];
    // When full, a simultaneous pop frees the head slot, which is exactly the tail slot.
    assign do_push    = push_i && !co_hit && (!full || pop_i);
    assign drop_o     = push_i && !co_hit && full && !pop_i;

    // Occupancy bits and ring pointers; flush empties the queue like reset.
    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            valid_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            if (pop_i) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= head_q + 1'b1;
            end
            if (do_push) begin
                valid_q[tail_q] <= 1'b1;
                tail_q          <= tail_q + 1'b1;
            end
        end
    end

    // Entry payload: in-place coalesce or fresh push; payload is qualified by valid_q.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (push_i && co_match[i]) begin
                data_q[i] <= push_data_i;
            end
        end
        if (do_push) begin
            idx_q[tail_q]  <= push_idx_i;
            data_q[tail_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/btb_wr_ctrl.sv
// btb_wr_ctrl: write-port controller for the branch target buffer RAM.
// Zero-sweeps the RAM after reset and on flush, commits each EX branch update
// once, defers writes that collide with the same-cycle read index, and
// forwards not-yet-written entries to the predictor read path.
// Optional build macro: BTB_WR_STATS_EN adds saturating event counters
// (stat_upd_o, stat_drop_o, stat_defer_o).
module btb_wr_ctrl #(
    parameter int IDX_W      = btb_pkg::IDX_W,
    parameter int DATA_W     = btb_pkg::DATA_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [5:0]        stall,
    input  logic              ex_upd_valid_i,
    input  logic [31:0]       ex_upd_pc_i,
    input  logic [DATA_W-1:0] ex_upd_data_i,
    input  logic              flush_req_i,
    input  logic [31:0]       rd_pc_i,
    output logic              btb_we_o,
    output logic [IDX_W-1:0]  btb_waddr_o,
    output logic [DATA_W-1:0] btb_wdata_o,
    output logic              rd_fwd_hit_o,
    output logic [DATA_W-1:0] rd_fwd_data_o,
    output logic              init_busy_o,
    output logic              upd_drop_o
`ifdef BTB_WR_STATS_EN
    ,
    output logic [31:0]       stat_upd_o,
    output logic [31:0]       stat_drop_o,
    output logic [31:0]       stat_defer_o
`endif
);

    import btb_pkg::*;

    btb_state_e        state_q;
    logic [IDX_W-1:0]  ptr_q;

    logic              we_q;
    logic [IDX_W-1:0]  waddr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              fwd_hit_q;
    logic [DATA_W-1:0] fwd_data_q;
    logic              busy_q;
    logic              drop_q;

    logic [IDX_W-1:0]  rd_idx;
    logic [IDX_W-1:0]  upd_idx;
    logic              in_run;
    logic              upd_arrive;
    logic              accept;
    logic              flush_go;
    logic              issue;
    logic              defer;
    logic              drop_d;

    logic              fifo_empty;
    logic [IDX_W-1:0]  fifo_head_idx;
    logic [DATA_W-1:0] fifo_head_data;
    logic              fifo_drop;
    logic              fifo_lk_hit;
    logic [DATA_W-1:0] fifo_lk_data;

    assign rd_idx     = rd_pc_i[IDX_W+1:2];
    assign upd_idx    = ex_upd_pc_i[IDX_W+1:2];
    assign in_run     = (state_q == RUN);
    // Only an unstalled EX cycle presents a branch; stalled repeats are ignored.
    assign upd_arrive = ex_upd_valid_i && !stall[3];
    assign accept     = in_run && upd_arrive;
    assign flush_go   = in_run && flush_req_i;
    // The head is held back while the RAM port reads the same index this cycle.
    assign defer      = in_run && !flush_go && !fifo_empty && (fifo_head_idx == rd_idx);
    assign issue      = in_run && !flush_go && !fifo_empty && (fifo_head_idx != rd_idx);
    assign drop_d     = (upd_arrive && !in_run) || fifo_drop;

    btb_upd_fifo #(
        .IDX_W  (IDX_W),
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .clear_i     (flush_go),
        .push_i      (accept),
        .push_idx_i  (upd_idx),
        .push_data_i (ex_upd_data_i),
        .pop_i       (issue),
        .lk_idx_i    (rd_idx),
        .empty_o     (fifo_empty),
        .head_idx_o  (fifo_head_idx),
        .head_data_o (fifo_head_data),
        .drop_o      (fifo_drop),
        .lk_hit_o    (fifo_lk_hit),
        .lk_data_o   (fifo_lk_data)
    );

    // Mode FSM: sweep pointer walks every index once per INIT/FLUSH, then RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= INIT;
            ptr_q   <= '0;
        end else begin
            case (state_q)
                INIT, FLUSH: begin
                    ptr_q <= ptr_q + 1'b1;
                    if (ptr_q == '1) begin
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (flush_req_i) begin
                        state_q <= FLUSH;
                        ptr_q   <= '0;
                    end
                end
                default: begin
                    state_q <= INIT;
                    ptr_q   <= '0;
                end
            endcase
        end
    end

    // Registered RAM write port, forwarding result and status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            we_q       <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            fwd_hit_q  <= 1'b0;
            fwd_data_q <= '0;
            busy_q     <= 1'b1;
            drop_q     <= 1'b0;
        end else begin
            busy_q <= !in_run;
            drop_q <= drop_d;
            if (!in_run) begin
                we_q       <= 1'b1;
                waddr_q    <= ptr_q;
                wdata_q    <= '0;
                fwd_hit_q  <= 1'b1;
                fwd_data_q <= '0;
            end else begin
                we_q <= issue;
                if (issue) begin
                    waddr_q <= fifo_head_idx;
                    wdata_q <= fifo_head_data;
                end
                // Queued data is newer than the write currently on the port.
                if (fifo_lk_hit) begin
                    fwd_hit_q  <= 1'b1;
                    fwd_data_q <= fifo_lk_data;
                end else if (we_q && (waddr_q == rd_idx)) begin
                    fwd_hit_q  <= 1'b1;
                    fwd_data_q <= wdata_q;
                end else begin
                    fwd_hit_q  <= 1'b0;
                    fwd_data_q <= '0;
                end
            end
        end
    end

    assign btb_we_o      = we_q;
    assign btb_waddr_o   = waddr_q;
    assign btb_wdata_o   = wdata_q;
    assign rd_fwd_hit_o  = fwd_hit_q;
    assign rd_fwd_data_o = fwd_data_q;
    assign init_busy_o   = busy_q;
    assign upd_drop_o    = drop_q;

`ifdef BTB_WR_STATS_EN
    logic [31:0] stat_upd_q;
    logic [31:0] stat_drop_q;
    logic [31:0] stat_defer_q;

    // Saturating event counters; flush leaves them untouched, only reset clears them.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_upd_q   <= '0;
            stat_drop_q  <= '0;
            stat_defer_q <= '0;
        end else begin
            if (accept) begin
                stat_upd_q <= sat_inc32(stat_upd_q);
            end
            if (drop_d) begin
                stat_drop_q <= sat_inc32(stat_drop_q);
            end
            if (defer) begin
                stat_defer_q <= sat_inc32(stat_defer_q);
            end
        end
    end

    assign stat_upd_o   = stat_upd_q;
    assign stat_drop_o  = stat_drop_q;
    assign stat_defer_o = stat_defer_q;
`else
    logic unused_defer;
    assign unused_defer = defer;
`endif

endmodule
